// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu : memory-stage load/store unit (req/ack data bus, MEM/WB drive)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic            regWriteIN,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] aluResultIN,
  input  logic [XLEN-1:0] writeDataIN,
  input  logic [4:0]      rdAddrIN,
  input  logic [XLEN-1:0] pcPlus4IN,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            validOUT,
  output logic            regWriteOUT,
  output logic [XLEN-1:0] readDataOUT,
  output logic [XLEN-1:0] aluResultOUT,
  output logic [4:0]      rdAddrOUT,
  output logic [XLEN-1:0] pcPlus4OUT,
  output logic            fault
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  // Fields captured when a request is launched
  logic [XLEN-1:0] r_lat_addr;
  logic [2:0]      r_lat_f3;
  logic [4:0]      r_lat_rd;
  logic            r_lat_rw;
  logic [XLEN-1:0] r_lat_pc4;
  logic            r_lat_store;

  logic            r_dmem_req, w_dmem_req_nxt;
  logic            r_dmem_we, w_dmem_we_nxt;
  logic [XLEN-1:0] r_dmem_addr, w_dmem_addr_nxt;
  logic [XLEN-1:0] r_dmem_wdata, w_dmem_wdata_nxt;
  logic [3:0]      r_dmem_be, w_dmem_be_nxt;

  logic            r_valid, w_valid_nxt;
  logic            r_rw, w_rw_nxt;
  logic [XLEN-1:0] r_rdata, w_rdata_nxt;
  logic [XLEN-1:0] r_alu, w_alu_nxt;
  logic [4:0]      r_rd, w_rd_nxt;
  logic [XLEN-1:0] r_pc4, w_pc4_nxt;
  logic            r_fault, w_fault_nxt;

  logic            w_stall;
  logic            w_mem_op;
  logic            w_f3_legal;
  logic            w_misalign;
  logic            w_bad;
  logic            w_accept;
  logic [3:0]      w_st_be;
  logic [XLEN-1:0] w_st_wdata;
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [XLEN-1:0] w_ld_data;

  assign w_mem_op = valid_in & (memRead | memWrite);

  always_comb begin
    w_f3_legal = 1'b0;
    if (memRead & ~memWrite) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_legal = 1'b1;
        default:                                w_f3_legal = 1'b0;
      endcase
    end else if (memWrite & ~memRead) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
        default:                w_f3_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   w_misalign = aluResultIN[0];
      2'b10:   w_misalign = (aluResultIN[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_bad    = ~w_f3_legal | w_misalign;
  assign w_accept = (r_state == S_IDLE) & w_mem_op & ~w_bad;

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << aluResultIN[1:0];
        w_st_wdata = {4{writeDataIN[7:0]}};
      end
      2'b01: begin
        w_st_be    = 4'b0011 << {aluResultIN[1], 1'b0};
        w_st_wdata = {2{writeDataIN[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = writeDataIN;
      end
    endcase
  end

  // Lane selection uses the byte offset captured at launch, not the live input
  assign w_ld_byte = dmem_rdata[{r_lat_addr[1:0], 3'b000} +: 8];
  assign w_ld_half = dmem_rdata[{r_lat_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (r_lat_f3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = '0;
    w_stall          = 1'b0;
    w_dmem_req_nxt   = 1'b0;
    w_dmem_we_nxt    = 1'b0;
    w_dmem_addr_nxt  = '0;
    w_dmem_wdata_nxt = '0;
    w_dmem_be_nxt    = 4'b0000;
    w_valid_nxt      = 1'b0;
    w_rw_nxt         = 1'b0;
    w_rdata_nxt      = '0;
    w_alu_nxt        = aluResultIN;
    w_rd_nxt         = rdAddrIN;
    w_pc4_nxt        = pcPlus4IN;
    w_fault_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_mem_op && w_bad) begin
          w_fault_nxt = 1'b1;
          w_valid_nxt = 1'b1;
        end else if (w_mem_op) begin
          w_stall          = 1'b1;
          w_state_nxt      = S_ACCESS;
          w_dmem_req_nxt   = 1'b1;
          w_dmem_we_nxt    = memWrite;
          w_dmem_addr_nxt  = {aluResultIN[XLEN-1:2], 2'b00};
          w_dmem_be_nxt    = memWrite ? w_st_be : 4'b1111;
          w_dmem_wdata_nxt = memWrite ? w_st_wdata : '0;
        end else begin
          w_valid_nxt = valid_in;
          w_rw_nxt    = regWriteIN & valid_in;
        end
      end

      S_ACCESS: begin
        w_alu_nxt = r_lat_addr;
        w_rd_nxt  = r_lat_rd;
        w_pc4_nxt = r_lat_pc4;
        if (dmem_ack) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b1;
          w_rw_nxt    = r_lat_rw;
          w_rdata_nxt = r_lat_store ? '0 : w_ld_data;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b1;
          w_fault_nxt = 1'b1;
        end else begin
          w_stall          = 1'b1;
          w_cnt_nxt        = r_cnt + CW'(1);
          w_dmem_req_nxt   = r_dmem_req;
          w_dmem_we_nxt    = r_dmem_we;
          w_dmem_addr_nxt  = r_dmem_addr;
          w_dmem_wdata_nxt = r_dmem_wdata;
          w_dmem_be_nxt    = r_dmem_be;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_addr  <= '0;
      r_lat_f3    <= 3'b000;
      r_lat_rd    <= 5'd0;
      r_lat_rw    <= 1'b0;
      r_lat_pc4   <= '0;
      r_lat_store <= 1'b0;
    end else if (w_accept) begin
      r_lat_addr  <= aluResultIN;
      r_lat_f3    <= funct3;
      r_lat_rd    <= rdAddrIN;
      r_lat_rw    <= regWriteIN;
      r_lat_pc4   <= pcPlus4IN;
      r_lat_store <= memWrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_be    <= 4'b0000;
      r_valid      <= 1'b0;
      r_rw         <= 1'b0;
      r_rdata      <= '0;
      r_alu        <= '0;
      r_rd         <= 5'd0;
      r_pc4        <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_dmem_req   <= w_dmem_req_nxt;
      r_dmem_we    <= w_dmem_we_nxt;
      r_dmem_addr  <= w_dmem_addr_nxt;
      r_dmem_wdata <= w_dmem_wdata_nxt;
      r_dmem_be    <= w_dmem_be_nxt;
      r_valid      <= w_valid_nxt;
      r_rw         <= w_rw_nxt;
      r_rdata      <= w_rdata_nxt;
      r_alu        <= w_alu_nxt;
      r_rd         <= w_rd_nxt;
      r_pc4        <= w_pc4_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  // Stall is forced low while reset is held so upstream never freezes in reset
  assign stall        = reset & w_stall;
  assign dmem_req     = r_dmem_req;
  assign dmem_we      = r_dmem_we;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_wdata   = r_dmem_wdata;
  assign dmem_be      = r_dmem_be;
  assign validOUT     = r_valid;
  assign regWriteOUT  = r_rw;
  assign readDataOUT  = r_rdata;
  assign aluResultOUT = r_alu;
  assign rdAddrOUT    = r_rd;
  assign pcPlus4OUT   = r_pc4;
  assign fault        = r_fault;

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It consumes the EX/MEM pipeline-register outputs: ALU result as address, store data, rd, PC+4 and the control bits.
- Performs the data-memory access over a req/ack bus with variable latency, stalling upstream while the access is outstanding.
- Aligns and sign-extends load data, then drives the MEM/WB pipeline register.
- Sits between the EX/MEM register and the writeback stage of the pipelined RISC-V core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in ACCESS waiting for dmem_ack before a bus fault is raised.
- XLEN, 32: data/address width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  EX/MEM entry holds a real instruction
- memRead  in  1  load
- memWrite  in  1  store
- regWriteIN  in  1  instruction writes rd
- funct3  in  3  access size/sign (RV32I encoding)
- aluResultIN  in  32  effective address / ALU result
- writeDataIN  in  32  store data (rs2)
- rdAddrIN  in  5  destination register
- pcPlus4IN  in  32  PC+4
- stall  out  1  upstream holds EX/MEM contents
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address (bits [1:0] = 0)
- dmem_wdata  out  32  lane-shifted store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  in  32  raw read word
- validOUT  out  1  MEM/WB entry valid
- regWriteOUT  out  1  gated register-write enable
- readDataOUT  out  32  extended load data
- aluResultOUT  out  32  pass-through ALU result
- rdAddrOUT  out  5  destination register
- pcPlus4OUT  out  32  PC+4
- fault  out  1  one-cycle pulse on misalign, illegal funct3, or timeout

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE, timeout counter 0, and every registered output 0: dmem_*, all *OUT, fault. stall reads 0 while in reset. If reset asserts mid-access, dmem_req drops immediately and the access is abandoned.
- FSM states: IDLE, ACCESS.
- Memory op = valid_in & (memRead | memWrite). memRead & memWrite both set is treated as illegal.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Alignment rules: halfword requires addr[0] = 0; word requires addr[1:0] = 0.
- IDLE, non-memory op or valid_in = 0: on the next edge the MEM/WB outputs load the inputs (readDataOUT = 0, validOUT = valid_in). Latency 1, no stall.
- IDLE, legal and aligned memory op:
  - stall = 1 combinationally.
  - At the edge: latch address, size and rd fields; drive dmem_req = 1, dmem_we, dmem_addr = {addr[31:2], 2'b00}, dmem_be and dmem_wdata; go to ACCESS.
  - MEM/WB loads a bubble (validOUT = 0, regWriteOUT = 0).
- Store lane rules:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 << {addr[1], 1'b0}; wdata = half replicated ×2.
  - SW: be = 1111.
- IDLE, illegal or misaligned memory op:
  - No request, no stall.
  - Next edge: fault = 1 and the instruction is written to MEM/WB with validOUT = 1, regWriteOUT = 0.
- ACCESS:
  - dmem_req and all dmem_* outputs are held stable until dmem_ack; the counter increments each cycle.
  - stall = ~dmem_ack.
  - MEM/WB loads bubbles while waiting.
- ACCESS with dmem_ack = 1:
  - At the edge, drop dmem_req and return to IDLE.
  - MEM/WB loads the latched fields with validOUT = 1 and regWriteOUT = latched regWriteIN.
  - readDataOUT = the selected byte/half from rdata[8*off +: n], sign- or zero-extended per funct3; for stores, readDataOUT = 0.
- Timeout: if the counter reaches TIMEOUT_CYCLES in ACCESS without ack:
  - Drop dmem_req; fault = 1 for one cycle; stall = 0 that cycle.
  - The entry is retired with regWriteOUT = 0; return to IDLE.
  - A dmem_ack in the same cycle as timeout wins (normal completion).
- Total load latency: presented at cycle T, dmem_req first high at T+1, ack at T+k, MEM/WB valid after the T+k edge. Upstream advances at the T+k edge.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle after completion. dmem_req is low for at least one cycle between requests.
- fault is a single-cycle pulse; it is never asserted together with a bubble.

Test Plan:
- Non-memory pass-through: ALU op, aluResultIN = 0x0000_1234, rd = 5, regWriteIN = 1 -> next cycle aluResultOUT = 0x1234, rdAddrOUT = 5, validOUT = 1, stall never high.
- LB with sign extension: addr 0x0000_0103, rdata = 0x80FF_0000, ack 3 cycles after req -> dmem_addr = 0x100, stall high 3 cycles, readDataOUT = 0xFFFF_FF80. LBU on the same stimulus -> 0x0000_0080.
- SH to 0x0000_0202, writeDataIN = 0xDEAD_BEEF, ack on first req cycle -> dmem_be = 1100, dmem_wdata = 0xBEEF_BEEF, dmem_we = 1, regWriteOUT = 0.
- Misaligned LW at 0x0000_0006 -> no dmem_req, fault pulse 1 cycle, regWriteOUT = 0, stall = 0.
- Timeout with TIMEOUT_CYCLES = 4 and no ack -> dmem_req drops after 4 ACCESS cycles, fault = 1, stall releases, regWriteOUT = 0. Repeat with ack on the 4th cycle -> normal completion, no fault.
- Reset mid-access: reset low 2 cycles after req -> dmem_req = 0 immediately, all outputs 0. After release, a new LW at 0x40 with rdata = 0x1234_5678 completes with readDataOUT = 0x1234_5678.
